// File: rtl/mixcol_sequencer_pkg.sv
// mixcol_sequencer_pkg: AES state geometry, sequencer FSM encoding and GF(2^8) doubling
package mixcol_sequencer_pkg;
  localparam int AES_NCOL = 4;
  localparam int AES_COLW = 32;
  localparam int AES_STATEW = 128;
  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
endpackage

// File: rtl/mixcol_sequencer_if.sv
// mixcol_sequencer_if: input and output valid/ready channels of the MixColumns sequencer
interface mixcol_sequencer_if;
  import mixcol_sequencer_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [AES_STATEW-1:0] in_state;
  logic in_bypass;
  logic out_valid;
  logic out_ready;
  logic [AES_STATEW-1:0] out_state;
  logic busy;
  modport slave(input in_valid, in_state, in_bypass, out_ready, output in_ready, out_valid, out_state, busy);
  modport master(output in_valid, in_state, in_bypass, out_ready, input in_ready, out_valid, out_state, busy);
endinterface

// File: rtl/mixcol_sequencer_mix.sv
// mixcol_sequencer_mix: combinational MixColumns on one 32-bit column, byte 0 in the MSBs
module mixcol_sequencer_mix
  import mixcol_sequencer_pkg::*;
(
  input  logic [AES_COLW-1:0] col,
  output logic [AES_COLW-1:0] mixed
);
  logic [7:0] a0, a1, a2, a3;
  assign {a0, a1, a2, a3} = col;
  assign mixed = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                  a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                  a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                  xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
endmodule

// File: rtl/mixcol_sequencer.sv
// mixcol_sequencer: column-serial MixColumns engine, COL_PER_CYC columns mixed per clock
module mixcol_sequencer
  import mixcol_sequencer_pkg::*;
#(
  parameter int COL_PER_CYC = 1
) (
  input logic clk,
  input logic rst_n,
  mixcol_sequencer_if.slave bus
);
  localparam logic [1:0] STEP = 2'(COL_PER_CYC);
  localparam logic [1:0] LAST = 2'(AES_NCOL - COL_PER_CYC);
  fsm_e fsm, fsm_nx;
  logic [AES_STATEW-1:0] st_q, st_mix;
  logic [1:0] col_q;
  logic accept;
  logic [AES_COLW-1:0] col_in [COL_PER_CYC];
  logic [AES_COLW-1:0] col_out [COL_PER_CYC];
  for (genvar i = 0; i < COL_PER_CYC; i++) begin : g_mix
    logic [1:0] c;
    assign c = col_q + 2'(i);
    assign col_in[i] = st_q[AES_STATEW-1-AES_COLW*int'(c) -: AES_COLW];
    mixcol_sequencer_mix u_mix (.col(col_in[i]), .mixed(col_out[i]));
  end
  // col_q is always a multiple of COL_PER_CYC, so col_q+k never passes column 3
  always_comb begin
    st_mix = st_q;
    for (int k = 0; k < COL_PER_CYC; k++)
      st_mix[AES_STATEW-1-AES_COLW*(int'(col_q)+k) -: AES_COLW] = col_out[k];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) fsm <= IDLE;
    else fsm <= fsm_nx;
  // an accept out of DONE drains and reloads on the same edge
  always_comb begin
    fsm_nx = accept ? (bus.in_bypass ? DONE : RUN) :
             (fsm == RUN) ? ((col_q == LAST) ? DONE : RUN) :
             (fsm == DONE && !bus.out_ready) ? DONE : IDLE;
  end
  always_comb begin
    bus.in_ready = (fsm == IDLE) || (fsm == DONE && bus.out_ready);
    bus.out_valid = (fsm == DONE);
    bus.busy = (fsm != IDLE);
    bus.out_state = st_q;
    accept = bus.in_valid && bus.in_ready;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st_q <= '0;
      col_q <= '0;
    end else if (accept) begin
      st_q <= bus.in_state;
      col_q <= '0;
    end else if (fsm == RUN) begin
      st_q <= st_mix;
      col_q <= col_q + STEP;
    end
endmodule

// File: tb/tb_mixcol_sequencer.sv
// tb_mixcol_sequencer: directed FIPS-197 MixColumns vectors, handshake, backpressure, reset and width sweep
module tb_mixcol_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  mixcol_sequencer_if b1 ();
  mixcol_sequencer_if b2 ();
  mixcol_sequencer_if b4 ();
  mixcol_sequencer #(.COL_PER_CYC(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  mixcol_sequencer #(.COL_PER_CYC(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  mixcol_sequencer #(.COL_PER_CYC(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  localparam logic [127:0] V1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] E1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V2 = 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6;
  localparam logic [127:0] E2 = 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6;
  int n_chk = 0;
  int n_err = 0;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic wait1(output int n);
    n = 0;
    while (!b1.out_valid && n < 20) begin
      tick;
      n++;
    end
  endtask
  initial begin
    int n;
    logic seen;
    {b1.in_valid, b1.in_bypass, b1.out_ready, b1.in_state} = '0;
    {b2.in_valid, b2.in_bypass, b2.out_ready, b2.in_state} = '0;
    {b4.in_valid, b4.in_bypass, b4.out_ready, b4.in_state} = '0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_in_ready", b1.in_ready, 1);
    check("rst_out_valid", b1.out_valid, 0);
    check("rst_out_state", b1.out_state, 0);
    check("rst_busy", b1.busy, 0);
    repeat (2) tick;
    rst_n = 1'b1;
    tick;
    b1.in_state = V1;
    b1.in_valid = 1'b1;
    tick;
    b1.in_valid = 1'b0;
    b1.in_state = '0;
    check("run_in_ready", b1.in_ready, 0);
    check("run_busy", b1.busy, 1);
    wait1(n);
    check("mix_latency", n, 4);
    check("mix_state", b1.out_state, E1);
    check("done_in_ready", b1.in_ready, 0);
    b1.out_ready = 1'b1;
    tick;
    b1.out_ready = 1'b0;
    check("drain_out_valid", b1.out_valid, 0);
    check("drain_busy", b1.busy, 0);
    b1.in_state = V1;
    b1.in_bypass = 1'b1;
    b1.in_valid = 1'b1;
    tick;
    b1.in_valid = 1'b0;
    b1.in_bypass = 1'b0;
    check("byp_out_valid", b1.out_valid, 1);
    check("byp_state", b1.out_state, V1);
    b1.in_state = V2;
    b1.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      check("bp_state", b1.out_state, V1);
      check("bp_out_valid", b1.out_valid, 1);
      check("bp_in_ready", b1.in_ready, 0);
    end
    b1.out_ready = 1'b1;
    #1;
    check("bp_release_ready", b1.in_ready, 1);
    tick;
    check("reload_out_valid", b1.out_valid, 0);
    check("reload_busy", b1.busy, 1);
    b1.in_state = V1;
    wait1(n);
    check("b2b_latency_1", n, 4);
    check("b2b_state_1", b1.out_state, E2);
    tick;
    b1.in_valid = 1'b0;
    check("b2b_reload_2", b1.out_valid, 0);
    wait1(n);
    check("b2b_latency_2", n, 4);
    check("b2b_state_2", b1.out_state, E1);
    tick;
    b1.out_ready = 1'b0;
    check("b2b_idle_busy", b1.busy, 0);
    b1.in_state = V1;
    b1.in_valid = 1'b1;
    tick;
    b1.in_valid = 1'b0;
    tick;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", b1.out_valid, 0);
    check("abort_busy", b1.busy, 0);
    check("abort_in_ready", b1.in_ready, 1);
    check("abort_state", b1.out_state, 0);
    tick;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick;
      seen |= b1.out_valid;
    end
    check("abort_no_stale", seen, 0);
    b2.in_state = V1;
    b2.in_valid = 1'b1;
    tick;
    b2.in_valid = 1'b0;
    n = 0;
    while (!b2.out_valid && n < 20) begin
      tick;
      n++;
    end
    check("cpc2_latency", n, 2);
    check("cpc2_state", b2.out_state, E1);
    b4.in_state = V1;
    b4.in_valid = 1'b1;
    tick;
    b4.in_valid = 1'b0;
    n = 0;
    while (!b4.out_valid && n < 20) begin
      tick;
      n++;
    end
    check("cpc4_latency", n, 1);
    check("cpc4_state", b4.out_state, E1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
